// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: scoreboard-based forwarding, load-use interlock, redirect flush and freeze control
module pipe_hazard_ctrl #(
   parameter int NUM_STAGES = 3,
   parameter int NUM_SRC    = 2,
   parameter int IDX_W      = 5,
   parameter int ALU_READY  = 1,
   parameter int LOAD_READY = 2,
   parameter int SEL_W      = $clog2(NUM_STAGES + 1),
   parameter int CNT_W      = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     id_valid,
   input  logic [NUM_SRC*IDX_W-1:0] id_src_idx,
   input  logic [NUM_SRC-1:0]       id_src_used,
   input  logic [IDX_W-1:0]         id_dst_idx,
   input  logic                     id_dst_we,
   input  logic                     id_is_load,
   input  logic                     redirect,
   input  logic                     freeze,
   output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
   output logic                     if_hold,
   output logic                     id_hold,
   output logic                     idex_bubble,
   output logic                     flush_ifid,
   output logic [NUM_STAGES-1:0]    slot_valid,
   output logic [CNT_W-1:0]         stall_cnt,
   output logic [CNT_W-1:0]         flush_cnt
);
   logic [NUM_STAGES-1:0]    sv, swe, sld;
   logic [IDX_W-1:0]         sdst [NUM_STAGES];
   logic [NUM_SRC*SEL_W-1:0] sel;
   logic [IDX_W-1:0]         src;
   logic [SEL_W-1:0]         mk;
   logic                     hit, rdy, stall, hazard, bub;
   always_comb begin
      sel   = '0;
      stall = 1'b0;
      src   = '0;
      mk    = '0;
      hit   = 1'b0;
      rdy   = 1'b0;
      for (int s = 0; s < NUM_SRC; s++) begin
         src = id_src_idx[s*IDX_W +: IDX_W];
         hit = 1'b0;
         rdy = 1'b0;
         mk  = '0;
         for (int k = NUM_STAGES; k >= 1; k--)
            if (sv[k-1] && swe[k-1] && sdst[k-1] == src) begin
               hit = 1'b1;
               mk  = SEL_W'(k);
               rdy = k >= (sld[k-1] ? LOAD_READY : ALU_READY);
            end
         if (id_src_used[s] && src != '0 && hit) begin
            if (rdy) sel[s*SEL_W +: SEL_W] = mk;
            else stall = 1'b1;
         end
      end
   end
   assign hazard      = id_valid & stall;
   assign bub         = redirect | hazard;
   assign fwd_sel     = rst ? '0 : sel;
   assign if_hold     = !rst && (freeze || (!redirect && hazard));
   assign id_hold     = if_hold;
   assign idex_bubble = !rst && !freeze && bub;
   assign flush_ifid  = !rst && !freeze && redirect;
   assign slot_valid  = sv;
   always_ff @(posedge clk) begin
      if (rst) begin
         sv        <= '0;
         swe       <= '0;
         sld       <= '0;
         for (int k = 0; k < NUM_STAGES; k++) sdst[k] <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (!freeze) begin
         sv      <= (sv << 1) | NUM_STAGES'(!bub && id_valid);
         swe     <= (swe << 1) | NUM_STAGES'(!bub && id_valid && id_dst_we);
         sld     <= (sld << 1) | NUM_STAGES'(!bub && id_is_load);
         sdst[0] <= bub ? '0 : id_dst_idx;
         for (int k = 1; k < NUM_STAGES; k++) sdst[k] <= sdst[k-1];
         if (redirect) flush_cnt <= flush_cnt + CNT_W'(flush_cnt != '1);
         else if (hazard) stall_cnt <= stall_cnt + CNT_W'(stall_cnt != '1);
      end
   end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench with an age-indexed reference model of in-flight producers
module tb_pipe_hazard_ctrl;
   localparam int N = 3;
   logic       clk = 1'b0;
   logic       rst, id_valid, id_dst_we, id_is_load, redirect, freeze;
   logic [9:0] id_src_idx;
   logic [1:0] id_src_used;
   logic [4:0] id_dst_idx;
   logic [3:0] fwd_sel, fwd_sel_b;
   logic       if_hold, id_hold, idex_bubble, flush_ifid;
   logic       if_hold_b, id_hold_b, idex_bubble_b, flush_ifid_b;
   logic [2:0] slot_valid, slot_valid_b;
   logic [15:0] stall_cnt, flush_cnt;
   logic [3:0]  stall_cnt_b, flush_cnt_b;

   pipe_hazard_ctrl dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_idx(id_src_idx),
      .id_src_used(id_src_used), .id_dst_idx(id_dst_idx), .id_dst_we(id_dst_we),
      .id_is_load(id_is_load), .redirect(redirect), .freeze(freeze),
      .fwd_sel(fwd_sel), .if_hold(if_hold), .id_hold(id_hold), .idex_bubble(idex_bubble),
      .flush_ifid(flush_ifid), .slot_valid(slot_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipe_hazard_ctrl #(.CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_idx(id_src_idx),
      .id_src_used(id_src_used), .id_dst_idx(id_dst_idx), .id_dst_we(id_dst_we),
      .id_is_load(id_is_load), .redirect(redirect), .freeze(freeze),
      .fwd_sel(fwd_sel_b), .if_hold(if_hold_b), .id_hold(id_hold_b), .idex_bubble(idex_bubble_b),
      .flush_ifid(flush_ifid_b), .slot_valid(slot_valid_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       v, we, ld;
      bit [4:0] dst;
   } ent_t;
   typedef struct {
      logic        ih, bub, fl;
      logic [3:0]  fwd;
      logic [2:0]  sv;
      logic [15:0] sc, fc;
      logic [3:0]  sc4, fc4;
   } exp_t;

   ent_t pipe [1:N];
   exp_t q[$];
   int   checks = 0, errors = 0;
   int   sc = 0, fc = 0, sc4 = 0, fc4 = 0;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", n, act, exp, $time);
      end
   endtask

   task automatic step(input bit r, input bit v, input bit [4:0] a, input bit [4:0] b,
                       input bit [1:0] u, input bit [4:0] d, input bit w, input bit l,
                       input bit rd, input bit fz);
      exp_t     e;
      bit       haz, found;
      bit [4:0] src;
      int       sel [2];
      rst = r; id_valid = v; id_src_idx = {b, a}; id_src_used = u;
      id_dst_idx = d; id_dst_we = w; id_is_load = l; redirect = rd; freeze = fz;
      haz = 1'b0;
      for (int s = 0; s < 2; s++) begin
         src = s ? b : a;
         sel[s] = 0;
         found = 1'b0;
         if (u[s] && src != 5'd0)
            for (int k = 1; k <= N; k++)
               if (!found && pipe[k].v && pipe[k].we && pipe[k].dst == src) begin
                  found = 1'b1;
                  if (k >= (pipe[k].ld ? 2 : 1)) sel[s] = k;
                  else haz = 1'b1;
               end
      end
      haz = haz && v;
      e.ih  = !r && (fz || (!rd && haz));
      e.bub = !r && !fz && (rd || haz);
      e.fl  = !r && !fz && rd;
      e.fwd = r ? 4'd0 : {2'(sel[1]), 2'(sel[0])};
      e.sv  = {pipe[3].v, pipe[2].v, pipe[1].v};
      e.sc  = 16'(sc); e.fc = 16'(fc); e.sc4 = 4'(sc4); e.fc4 = 4'(fc4);
      q.push_back(e);
      @(posedge clk);
      if (r) begin
         for (int k = 1; k <= N; k++) pipe[k] = '{0, 0, 0, 5'd0};
         sc = 0; fc = 0; sc4 = 0; fc4 = 0;
      end else if (!fz) begin
         if (rd) begin
            fc  = (fc < 65535) ? fc + 1 : fc;
            fc4 = (fc4 < 15) ? fc4 + 1 : fc4;
         end else if (haz) begin
            sc  = (sc < 65535) ? sc + 1 : sc;
            sc4 = (sc4 < 15) ? sc4 + 1 : sc4;
         end
         for (int k = N; k >= 2; k--) pipe[k] = pipe[k-1];
         pipe[1] = (rd || haz) ? '{0, 0, 0, 5'd0} : '{v, w && v, l, d};
      end
      #1;
   endtask

   task automatic nop();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("if_hold", if_hold, e.ih);
            chk("id_hold", id_hold, e.ih);
            chk("idex_bubble", idex_bubble, e.bub);
            chk("flush_ifid", flush_ifid, e.fl);
            chk("fwd_sel", fwd_sel, e.fwd);
            chk("slot_valid", slot_valid, e.sv);
            chk("stall_cnt", stall_cnt, e.sc);
            chk("flush_cnt", flush_cnt, e.fc);
            chk("stall_cnt_sat4", stall_cnt_b, e.sc4);
            chk("flush_cnt_sat4", flush_cnt_b, e.fc4);
         end
      end
   end

   initial begin
      rst = 1; id_valid = 0; id_src_idx = '0; id_src_used = '0; id_dst_idx = '0;
      id_dst_we = 0; id_is_load = 0; redirect = 0; freeze = 0;
      @(posedge clk); #1;
      repeat (2) step(1, 1, 3, 3, 3, 3, 1, 1, 1, 0);
      step(0, 1, 1, 2, 3, 3, 1, 0, 0, 0);
      step(0, 1, 3, 5, 3, 4, 1, 0, 0, 0);
      for (int g = 1; g <= 3; g++) begin
         step(0, 1, 1, 2, 3, 3, 1, 0, 0, 0);
         repeat (g) nop();
         step(0, 1, 3, 5, 3, 4, 1, 0, 0, 0);
      end
      step(0, 1, 1, 0, 1, 8, 1, 1, 0, 0);
      repeat (2) step(0, 1, 8, 8, 3, 9, 1, 0, 0, 0);
      step(0, 1, 1, 0, 1, 0, 1, 1, 0, 0);
      step(0, 1, 0, 0, 3, 9, 1, 0, 0, 0);
      step(0, 1, 1, 1, 3, 2, 1, 0, 0, 0);
      step(0, 1, 1, 0, 1, 2, 1, 1, 0, 0);
      repeat (2) step(0, 1, 2, 2, 3, 7, 1, 0, 0, 0);
      step(0, 1, 1, 0, 1, 8, 1, 1, 0, 0);
      step(0, 1, 8, 8, 3, 9, 1, 0, 1, 0);
      step(0, 1, 1, 0, 1, 6, 1, 1, 0, 0);
      repeat (3) step(0, 1, 6, 6, 3, 7, 1, 0, 1, 1);
      repeat (2) step(0, 1, 6, 6, 3, 7, 1, 0, 0, 0);
      repeat (3000)
         step(1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 9) < 8),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0));
      repeat (3) nop();
      @(negedge clk);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
